// File: rtl/cv32e40s_pkg.sv
// Shared OBI data-interface types and integrity helpers used by the core-side master and
// by the memory responder.
package cv32e40s_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  prot;
    logic [1:0]  memtype;
    logic        dbg;
    logic [11:0] achk;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        exokay;
    logic [4:0]  rchk;
  } obi_data_resp_t;

  // Entry held in the responder's in-order response FIFO.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_entry_t;

  // Odd parity per group:
  //   [3:0]  = address bytes 0..3
  //   [4]    = {prot, memtype}
  //   [5]    = {be, we}
  //   [6]    = dbg
  //   [7]    = atop group; atomics are absent, so the group is empty
  //   [11:8] = wdata bytes 0..3
  function automatic logic [11:0] obi_data_achk(obi_data_req_t req);
    logic [11:0] chk;
    for (int unsigned i = 0; i < 4; i++) begin
      chk[i]     = ~^req.addr[8*i +: 8];
      chk[8 + i] = ~^req.wdata[8*i +: 8];
    end
    chk[4] = ~^{req.prot, req.memtype};
    chk[5] = ~^{req.be, req.we};
    chk[6] = ~^req.dbg;
    chk[7] = 1'b1;
    return chk;
  endfunction

  function automatic logic [4:0] obi_data_rchk(logic [31:0] rdata, logic err, logic exokay);
    logic [4:0] chk;
    for (int unsigned i = 0; i < 4; i++) begin
      chk[i] = ~^rdata[8*i +: 8];
    end
    chk[4] = ~^{err, exokay};
    return chk;
  endfunction

endpackage

// File: rtl/cv32e40s_obi_resp_fifo.sv
// In-order response FIFO: circular buffer with explicit count, so any depth (including
// non-power-of-2 depths) wraps correctly.
module cv32e40s_obi_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = store[rd_ptr];

  // Storage is cleared so the head reads as an all-zero entry out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= wdata;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40s_data_obi_responder.sv
// OBI data-side responder backed by a word-addressed local RAM, with request integrity
// checking and response integrity generation.
module cv32e40s_data_obi_responder
  import cv32e40s_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_i,
  input  logic           reqpar_i,
  output logic           gnt_o,
  output logic           gntpar_o,
  input  obi_data_req_t  req_payload_i,
  output logic           rvalid_o,
  output logic           rvalidpar_o,
  output obi_data_resp_t resp_payload_o,
  input  logic           resp_stall_i,
  output logic           integrity_err_o
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             addr_err;
  logic             chk_err;
  logic             acc_err;
  logic             integrity_q;
  obi_resp_entry_t  push_entry;
  obi_resp_entry_t  head;

  // No push/pop bypass: a full FIFO refuses even when the head leaves this cycle.
  assign gnt_o    = req_i && !fifo_full;
  assign gntpar_o = !gnt_o;
  assign accept   = req_i && gnt_o;

  assign word_idx = req_payload_i.addr[IDX_W+1:2];
  assign addr_err = ({2'b00, req_payload_i.addr[31:2]} >= 32'(MEM_WORDS));
  assign chk_err  = (req_payload_i.achk != obi_data_achk(req_payload_i));
  assign acc_err  = addr_err || chk_err;

  // Reads see the word as it was before any same-cycle write; writes and errors return 0.
  always_comb begin
    push_entry       = '0;
    push_entry.err   = acc_err;
    if (!req_payload_i.we && !acc_err) begin
      push_entry.rdata = mem[word_idx];
    end
  end

  // Memory has no reset so contents survive a reset of the interface logic.
  always_ff @(posedge clk) begin
    if (accept && req_payload_i.we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_payload_i.be[b]) begin
          mem[word_idx][8*b +: 8] <= req_payload_i.wdata[8*b +: 8];
        end
      end
    end
  end

  cv32e40s_obi_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (obi_resp_entry_t)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (push_entry),
    .pop   (rvalid_o),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rvalid_o    = !fifo_empty && !resp_stall_i;
  assign rvalidpar_o = !rvalid_o;

  always_comb begin
    resp_payload_o        = '0;
    resp_payload_o.rdata  = head.rdata;
    resp_payload_o.err    = head.err;
    resp_payload_o.exokay = 1'b0;
    resp_payload_o.rchk   = obi_data_rchk(head.rdata, head.err, 1'b0);
  end

  // reqpar is checked every cycle; achk only matters for transfers actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integrity_q <= 1'b0;
    end else begin
      integrity_q <= (reqpar_i == req_i) || (accept && chk_err);
    end
  end

  assign integrity_err_o = integrity_q;

endmodule
